// File: rtl/conv_pool_pipe.sv
`default_nettype none
// ============================================================================
// Module  : conv_pool_pipe
// Brief   : Three-stage streaming 4x4-tile 3x3 conv + saturate + 2x2 pool,
//           NUM_CH channels, valid/ready flow control, shared output address.
//           Optional feature macro: POOL_AVG_EN (average pooling via pool_mode).
// Revision: 1.0 - initial release
// ============================================================================
module conv_pool_pipe #(
  parameter int NUM_CH  = 3,
  parameter int KW      = 8,
  parameter int FRAC    = 3,
  parameter int ADDR_W  = 16,
  parameter int SHIFT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             image_4x4,
  input  logic [NUM_CH*9*KW-1:0]   kernels,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     pool_mode,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_we,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [NUM_CH*8-1:0]      y
);

  localparam int C_ACC_W = 8 + KW + 4;
  localparam int C_PW    = KW + 9;

  logic                      s1_valid_q;
  logic                      s2_valid_q;
  logic                      out_valid_q;
  logic                      s1_adv;
  logic                      s2_adv;
  logic                      out_free;
  logic [127:0]              s1_img_q;
  logic [NUM_CH*9*KW-1:0]    s1_kern_q;
  logic [SHIFT_W-1:0]        s1_shift_q;
  logic [SHIFT_W-1:0]        s2_shift_q;
  logic signed [C_ACC_W-1:0] sum_d    [NUM_CH][4];
  logic signed [C_ACC_W-1:0] s2_sum_q [NUM_CH][4];
  logic [NUM_CH*8-1:0]       y_d;
  logic [NUM_CH*8-1:0]       y_q;
  logic [ADDR_W-1:0]         addr_d;
  logic [ADDR_W-1:0]         addr_q;

  // A stage may move forward only when the stage after it is empty or moving.
  assign out_free = !out_valid_q || out_ready;
  assign s2_adv   = s2_valid_q && out_free;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || s2_adv);
  assign in_ready = !s1_valid_q || s1_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_img_q   <= '0;
      s1_kern_q  <= '0;
      s1_shift_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_img_q   <= image_4x4;
        s1_kern_q  <= kernels;
        s1_shift_q <= shift;
      end
    end
  end

  // Convolution: each product is truncated by FRAC before it joins the sum.
  logic [7:0]               cv_pix;
  logic [KW-1:0]            cv_coef;
  logic signed [C_PW-1:0]   cv_opa;
  logic signed [C_PW-1:0]   cv_opb;
  logic signed [C_PW-1:0]   cv_prod;
  logic signed [C_PW-1:0]   cv_prod_sh;
  logic signed [C_ACC_W-1:0] cv_acc;

  always_comb begin
    cv_pix     = '0;
    cv_coef    = '0;
    cv_opa     = '0;
    cv_opb     = '0;
    cv_prod    = '0;
    cv_prod_sh = '0;
    cv_acc     = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      for (int p = 0; p < 4; p++) begin
        cv_acc = '0;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            cv_pix     = s1_img_q[(((p / 2) + ky) * 4 + (p % 2) + kx) * 8 +: 8];
            cv_coef    = s1_kern_q[(n * 9 + ky * 3 + kx) * KW +: KW];
            cv_opa     = {{(KW + 1){1'b0}}, cv_pix};
            cv_opb     = {{9{cv_coef[KW-1]}}, cv_coef};
            cv_prod    = cv_opa * cv_opb;
            cv_prod_sh = cv_prod >>> FRAC;
            cv_acc     = cv_acc + {{(C_ACC_W - C_PW){cv_prod_sh[C_PW-1]}}, cv_prod_sh};
          end
        end
        sum_d[n][p] = cv_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_shift_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        for (int p = 0; p < 4; p++) begin
          s2_sum_q[n][p] <= '0;
        end
      end
    end else begin
      if (!s2_valid_q || s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_adv) begin
        s2_shift_q <= s1_shift_q;
        for (int n = 0; n < NUM_CH; n++) begin
          for (int p = 0; p < 4; p++) begin
            s2_sum_q[n][p] <= sum_d[n][p];
          end
        end
      end
    end
  end

`ifdef POOL_AVG_EN
  logic s1_pmode_q;
  logic s2_pmode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pmode_q <= 1'b0;
      s2_pmode_q <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_pmode_q <= pool_mode;
      end
      if (s1_adv) begin
        s2_pmode_q <= s1_pmode_q;
      end
    end
  end
`else
  logic unused_pool_mode;
  assign unused_pool_mode = pool_mode;
`endif

  logic signed [C_ACC_W-1:0] pl_shv;
  logic [7:0]                pl_sat;
  logic [7:0]                pl_max;
`ifdef POOL_AVG_EN
  logic [9:0]                pl_tot;
`endif

  always_comb begin
    y_d    = '0;
    pl_shv = '0;
    pl_sat = '0;
    pl_max = '0;
`ifdef POOL_AVG_EN
    pl_tot = '0;
`endif
    for (int n = 0; n < NUM_CH; n++) begin
      pl_max = '0;
`ifdef POOL_AVG_EN
      pl_tot = '0;
`endif
      for (int p = 0; p < 4; p++) begin
        pl_shv = s2_sum_q[n][p] >>> s2_shift_q;
        if (pl_shv[C_ACC_W-1]) begin
          pl_sat = 8'h00;
        end else if (|pl_shv[C_ACC_W-2:8]) begin
          pl_sat = 8'hFF;
        end else begin
          pl_sat = pl_shv[7:0];
        end
        if (pl_sat > pl_max) begin
          pl_max = pl_sat;
        end
`ifdef POOL_AVG_EN
        pl_tot = pl_tot + {2'b00, pl_sat};
`endif
      end
`ifdef POOL_AVG_EN
      y_d[n*8 +: 8] = s2_pmode_q ? pl_tot[9:2] : pl_max;
`else
      y_d[n*8 +: 8] = pl_max;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      if (out_free) begin
        out_valid_q <= s2_valid_q;
      end
      if (s2_adv) begin
        y_q <= y_d;
      end
    end
  end

  // A start pulse overrides the increment from a coincident transfer.
  always_comb begin
    addr_d = addr_q;
    if (start) begin
      addr_d = base_addr;
    end else if (out_valid_q && out_ready) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_we    = {NUM_CH{out_valid_q && out_ready}};
  assign out_addr  = addr_q;
  assign y         = y_q;

endmodule

`default_nettype wire
